eos_param: RTL and testbench

EOS_PARAM -- requirements
Module: eos_param

---
 rtl/eos_param.sv | 151 +++++++++++++++
 tb/tb_eos_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eos_param.sv
// Egress metadata scheduler: CQF queue pair, token-bucket shaped queue and
// best-effort queues served by strict priority into a registered output.
`timescale 1ns/1ps
module eos_param #(
    parameter int NUM_Q      = 4,
    parameter int MD_W       = 8,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int TICK_CYC   = 256
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [MD_W-1:0]                           in_md,
    input  logic [LEN_W-1:0]                          in_md_len,
    input  logic [$clog2(NUM_Q)-1:0]                  in_md_qid,
    input  logic                                      in_md_wr,
    input  logic                                      in_time_slot_flag,
    input  logic [15:0]                               in_rate_limit,
    input  logic [15:0]                               in_depth_limit,
    input  logic                                      in_ready,
    output logic [MD_W-1:0]                           out_md,
    output logic                                      out_md_wr,
    output logic [NUM_Q*($clog2(FIFO_DEPTH)+1)-1:0]   out_q_used,
    output logic [31:0]                               out_drop_cnt,
    output logic [63:0]                               out_mdin_cnt,
    output logic [63:0]                               out_mdout_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int QW = $clog2(NUM_Q);
    localparam int EW = LEN_W + MD_W;
    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic              slot_q;
    logic [EW-1:0]     mem [NUM_Q][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [NUM_Q];
    logic [AW-1:0]     rd_ptr [NUM_Q];
    logic [AW:0]       used [NUM_Q];
    logic [15:0]       tokens;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [QW-1:0]     tx_q;
    logic [QW-1:0]     enq_q;
    logic [QW-1:0]     deq_q_p0;
    logic              enq_ok;
    logic              enq_acc;
    logic              deq_vld_p0;
    logic [NUM_Q-1:0]  wr_en;
    logic [NUM_Q-1:0]  rd_en;
    logic [LEN_W-1:0]  q2_len;
    logic [15:0]       tok_used;
    logic [16:0]       tok_sum;
    logic [15:0]       tok_next;

    // Strict-priority pick for this cycle; transmit queue is the one not being filled.
    always_comb begin
        tx_q       = {{(QW-1){1'b0}}, ~slot_q};
        q2_len     = mem[2][rd_ptr[2]][EW-1:MD_W];
        deq_vld_p0 = 1'b0;
        deq_q_p0   = '0;
        if (in_ready) begin
            if (used[tx_q] != '0) begin
                deq_vld_p0 = 1'b1;
                deq_q_p0   = tx_q;
            end else if (used[2] != '0 && tokens >= 16'(q2_len)) begin
                deq_vld_p0 = 1'b1;
                deq_q_p0   = QW'(2);
            end else begin
                for (int k = NUM_Q - 1; k >= 3; k--) begin
                    if (used[k] != '0) begin
                        deq_vld_p0 = 1'b1;
                        deq_q_p0   = QW'(k);
                    end
                end
            end
        end
    end

    // A full queue still accepts a write when it is being read in the same cycle.
    always_comb begin
        enq_q   = (in_md_qid <= QW'(1)) ? {{(QW-1){1'b0}}, slot_q} : in_md_qid;
        enq_ok  = in_md_wr && ({1'b0, in_md_qid} < (QW+1)'(NUM_Q));
        enq_acc = enq_ok && ((used[enq_q] != (AW+1)'(FIFO_DEPTH)) ||
                             (deq_vld_p0 && deq_q_p0 == enq_q));
        wr_en   = '0;
        rd_en   = '0;
        if (enq_acc)    wr_en[enq_q]    = 1'b1;
        if (deq_vld_p0) rd_en[deq_q_p0] = 1'b1;
    end

    // Consume first, then refill, then clamp to the bucket ceiling.
    always_comb begin
        tick     = (tick_cnt == TW'(TICK_CYC - 1));
        tok_used = tokens - ((deq_vld_p0 && deq_q_p0 == QW'(2)) ? 16'(q2_len) : 16'd0);
        tok_sum  = {1'b0, tok_used} + {1'b0, in_rate_limit};
        tok_next = tok_used;
        if (tick) begin
            tok_next = (tok_sum > {1'b0, in_depth_limit}) ? in_depth_limit : tok_sum[15:0];
        end
    end

    always_comb begin
        out_q_used = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            out_q_used[i*(AW+1) +: AW+1] = used[i];
        end
    end

    always_ff @(posedge clk) begin
        if (enq_acc) begin
            mem[enq_q][wr_ptr[enq_q]] <= {in_md_len, in_md};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= 1'b0;
            tokens        <= '0;
            tick_cnt      <= '0;
            out_md        <= '0;
            out_md_wr     <= 1'b0;
            out_drop_cnt  <= '0;
            out_mdin_cnt  <= '0;
            out_mdout_cnt <= '0;
            for (int i = 0; i < NUM_Q; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                used[i]   <= '0;
            end
        end else begin
            slot_q    <= in_time_slot_flag;
            tokens    <= tok_next;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            out_md_wr <= deq_vld_p0;
            if (deq_vld_p0) begin
                out_md        <= mem[deq_q_p0][rd_ptr[deq_q_p0]][MD_W-1:0];
                out_mdout_cnt <= out_mdout_cnt + 64'd1;
            end
            if (enq_acc) out_mdin_cnt <= out_mdin_cnt + 64'd1;
            if (in_md_wr && !enq_acc && out_drop_cnt != '1) out_drop_cnt <= out_drop_cnt + 32'd1;
            for (int i = 0; i < NUM_Q; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({wr_en[i], rd_en[i]})
                    2'b10:   used[i] <= used[i] + 1'b1;
                    2'b01:   used[i] <= used[i] - 1'b1;
                    default: used[i] <= used[i];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eos_param.sv
// Scoreboard bench for eos_param: expected metadata queued at stimulus time,
// popped and compared whenever the DUT emits out_md_wr.
`timescale 1ns/1ps
module tb_eos_param;
    localparam int NUM_Q = 4;
    localparam int MD_W = 8;
    localparam int LEN_W = 11;
    localparam int FIFO_DEPTH = 16;
    localparam int TICK_CYC = 256;
    localparam int UW = 5;

    logic              clk;
    logic              rst;
    logic [MD_W-1:0]   in_md;
    logic [LEN_W-1:0]  in_md_len;
    logic [1:0]        in_md_qid;
    logic              in_md_wr;
    logic              in_time_slot_flag;
    logic [15:0]       in_rate_limit;
    logic [15:0]       in_depth_limit;
    logic              in_ready;
    logic [MD_W-1:0]   out_md;
    logic              out_md_wr;
    logic [NUM_Q*UW-1:0] out_q_used;
    logic [31:0]       out_drop_cnt;
    logic [63:0]       out_mdin_cnt;
    logic [63:0]       out_mdout_cnt;

    eos_param #(.NUM_Q(NUM_Q), .MD_W(MD_W), .LEN_W(LEN_W),
                .FIFO_DEPTH(FIFO_DEPTH), .TICK_CYC(TICK_CYC)) dut (
        .clk(clk), .rst(rst), .in_md(in_md), .in_md_len(in_md_len),
        .in_md_qid(in_md_qid), .in_md_wr(in_md_wr),
        .in_time_slot_flag(in_time_slot_flag), .in_rate_limit(in_rate_limit),
        .in_depth_limit(in_depth_limit), .in_ready(in_ready),
        .out_md(out_md), .out_md_wr(out_md_wr), .out_q_used(out_q_used),
        .out_drop_cnt(out_drop_cnt), .out_mdin_cnt(out_mdin_cnt),
        .out_mdout_cnt(out_mdout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_cyc = 0;
    int mdin_exp = 0;
    int mdout_exp = 0;
    logic [7:0] exp_q[$];
    int out_cyc[$];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_md_wr === 1'b1) begin
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("out_md", 64'(out_md), 64'(e));
                out_cyc.push_back(cyc);
                last_cyc = cyc;
            end else begin
                chk("spurious_wr", 64'(out_md_wr), 64'd0);
            end
        end
    end

    function automatic logic [UW-1:0] used_q(input int i);
        return out_q_used[i*UW +: UW];
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int q, input logic [7:0] md, input int len, input bit acc);
        in_md     = md;
        in_md_len = LEN_W'(len);
        in_md_qid = 2'(q);
        in_md_wr  = 1'b1;
        step(1);
        in_md_wr  = 1'b0;
        if (acc) mdin_exp++;
    endtask

    task automatic expect_md(input logic [7:0] md);
        exp_q.push_back(md);
        mdout_exp++;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_md"}, 64'(out_md), 64'd0);
        chk({tag, "_out_md_wr"}, 64'(out_md_wr), 64'd0);
        chk({tag, "_q_used"}, 64'(out_q_used), 64'd0);
        chk({tag, "_drop"}, 64'(out_drop_cnt), 64'd0);
        chk({tag, "_mdin"}, out_mdin_cnt, 64'd0);
        chk({tag, "_mdout"}, out_mdout_cnt, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_md = '0;
        in_md_len = '0;
        in_md_qid = '0;
        in_md_wr = 1'b0;
        in_time_slot_flag = 1'b0;
        in_rate_limit = 16'd100;
        in_depth_limit = 16'd300;
        in_ready = 1'b1;
        step(3);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // CQF: written in slot 0, released in order once the slot flips
        for (int i = 0; i < 3; i++) wr(0, 8'h11 + 8'(i), 10, 1'b1);
        step(5);
        chk("ts_held_q0", 64'(used_q(0)), 64'd3);
        out_cyc.delete();
        for (int i = 0; i < 3; i++) expect_md(8'h11 + 8'(i));
        in_time_slot_flag = 1'b1;
        drain(20);
        chk("ts_count", 64'(out_cyc.size()), 64'd3);
        if (out_cyc.size() == 3) chk("ts_b2b", 64'(out_cyc[2] - out_cyc[0]), 64'd2);

        // Fill q3 and overflow by one
        in_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(3, 8'h30 + 8'(i), 5, 1'b1);
        wr(3, 8'hEE, 5, 1'b0);
        chk("drop_cnt", 64'(out_drop_cnt), 64'd1);
        chk("q3_full", 64'(used_q(3)), 64'd16);

        // Write and read a full q3 in the same cycle
        for (int i = 0; i < 16; i++) expect_md(8'h30 + 8'(i));
        expect_md(8'h40);
        in_ready = 1'b1;
        wr(3, 8'h40, 5, 1'b1);
        in_ready = 1'b0;
        chk("full_rw_used", 64'(used_q(3)), 64'd16);
        chk("full_rw_drop", 64'(out_drop_cnt), 64'd1);
        in_ready = 1'b1;
        drain(40);

        // Priority TS > q2 > q3, with ready held low first
        in_ready = 1'b0;
        wr(0, 8'hA1, 3, 1'b1);
        wr(2, 8'hB1, 0, 1'b1);
        wr(3, 8'hC1, 7, 1'b1);
        in_time_slot_flag = 1'b0;
        step(6);
        expect_md(8'hA1);
        expect_md(8'hB1);
        expect_md(8'hC1);
        in_ready = 1'b1;
        drain(20);
        chk("mdin_cnt", out_mdin_cnt, 64'(mdin_exp));
        chk("mdout_cnt", out_mdout_cnt, 64'(mdout_exp));

        // Token bucket: fresh reset aligns the tick grid with cyc
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        mdin_exp = 0;
        mdout_exp = 0;
        wr(2, 8'hD1, 200, 1'b1);
        while (cyc < 400) step(1);
        expect_md(8'hD1);
        drain(300);
        chk("rate_first_cyc", 64'(last_cyc), 64'd513);
        wr(2, 8'hD2, 200, 1'b1);
        while (cyc < 900) step(1);
        expect_md(8'hD2);
        drain(300);
        chk("rate_empty_cyc", 64'(last_cyc), 64'd1025);
        while (cyc < 2058) step(1);
        expect_md(8'hE1);
        expect_md(8'hE2);
        wr(2, 8'hE1, 200, 1'b1);
        wr(2, 8'hE2, 100, 1'b1);
        wr(2, 8'hE3, 1, 1'b1);
        drain(40);
        chk("ceil_q2_pending", 64'(used_q(2)), 64'd1);
        expect_md(8'hE3);
        drain(400);
        chk("ceil_next_cyc", 64'(last_cyc), 64'd2305);

        // Reset with queued entries
        in_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(3, 8'h50 + 8'(i), 4, 1'b1);
            wr(0, 8'h60 + 8'(i), 4, 1'b1);
        end
        chk("pre_rst_q3", 64'(used_q(3)), 64'd4);
        chk("pre_rst_q0", 64'(used_q(0)), 64'd4);
        chk("pre_rst_mdin", out_mdin_cnt, 64'(mdin_exp));
        chk("pre_rst_mdout", out_mdout_cnt, 64'(mdout_exp));
        in_ready = 1'b1;
        rst = 1'b1;
        step(2);
        @(negedge clk);
        chk_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        step(10);
        chk_zero("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
